lr_line_fit: RTL and testbench

//  Per-frame least-squares line fit over masked pixels, plus line overlay for display.

---
 rtl/lr_line_fit_pkg.sv | 28 ++
 rtl/lr_line_fit_if.sv | 14 +
 rtl/lr_divider.sv | 84 ++++++++
 rtl/lr_line_fit.sv | 175 +++++++++++++++++
 tb/tb_lr_line_fit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/lr_line_fit_pkg.sv
// Shared types and constants for the least-squares line-fit block.
// Package name: lr_pkg.
//   H_W/V_W     : pixel coordinate widths
//   ACC_W       : width of each running sum
//   FRAC_BITS   : fractional bits of slope/offset
//   TOL         : half-thickness of the drawn line (LR_THICK_EN builds)
//   solve_state_e : solver FSM states
package lr_pkg;
  localparam int H_W       = 11;
  localparam int V_W       = 10;
  localparam int ACC_W     = 48;
  localparam int FRAC_BITS = 8;
  localparam int PROD_W    = 2 * ACC_W;
  localparam int TOL       = 1;

  typedef logic        [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  coef_t;

  typedef enum logic [2:0] {IDLE, MUL, DIV_M, MUL_B, DIV_B, COMMIT} solve_state_e;

  // Saturating unsigned add: sums pin at all-ones instead of wrapping.
  function automatic acc_t sat_add(acc_t a, acc_t b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/lr_line_fit_if.sv
// Video-side bundle for the line-fit block.
//   hcount/vcount : current pixel coordinate
//   mask_cr       : pixel belongs to the tracked object
//   lin_reg_line  : pixel lies on the fitted line (from the fitter)
// master drives the raster, slave is the fitter.
interface lr_line_fit_if;
  logic [lr_pkg::H_W-1:0] hcount;
  logic [lr_pkg::V_W-1:0] vcount;
  logic                   mask_cr;
  logic                   lin_reg_line;

  modport master (output hcount, vcount, mask_cr, input lin_reg_line);
  modport slave  (input hcount, vcount, mask_cr, output lin_reg_line);
endinterface

// File: rtl/lr_divider.sv
// Signed restoring divider, quotient truncated toward zero.
//   start_i    : load operands (ignored while busy)
//   dividend_i : signed W-bit numerator
//   divisor_i  : signed W-bit denominator (caller guarantees non-zero)
//   busy_o     : iterating
//   done_o     : one-cycle pulse; quotient_o valid from then until next start
module lr_divider #(
  parameter int W = 96
) (
  input  logic                clk_65mhz,
  input  logic                rst_in,
  input  logic                start_i,
  input  logic signed [W-1:0] dividend_i,
  input  logic signed [W-1:0] divisor_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [W-1:0] quotient_o
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     num_q, num_d;   // dividend magnitude, shifts into quotient
  logic [W-1:0]     den_q, den_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W:0]       rem_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    num_d  = num_q;
    den_d  = den_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_sh = {rem_q, num_q[W-1]};
    if (start_i && !busy_q) begin
      num_d  = dividend_i[W-1] ? (~dividend_i + W'(1)) : dividend_i;
      den_d  = divisor_i[W-1]  ? (~divisor_i + W'(1))  : divisor_i;
      neg_d  = dividend_i[W-1] ^ divisor_i[W-1];
      rem_d  = '0;
      cnt_d  = CNT_W'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // rem_sh < 2*den, so the difference always fits back into W bits
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d = rem_sh[W-1:0] - den_q;
        num_d = {num_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        num_d = {num_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = neg_q ? $signed(~num_q + W'(1)) : $signed(num_q);
endmodule

// File: rtl/lr_line_fit.sv
// Per-frame least-squares fit y = m*x + b over masked pixels, with line overlay.
//   clk_65mhz : pixel clock
//   rst_in    : asynchronous active-low reset
//   vid       : raster in (hcount, vcount, mask_cr), lin_reg_line out (registered)
// Build option: define LR_THICK_EN to draw a line of half-thickness TOL.
//
// Solver states:
//   IDLE   | waiting for a frame end with data
//   MUL    | form den/num, start slope (or column) division
//   DIV_M  | dividing for the slope
//   MUL_B  | form offset numerator, start offset division
//   DIV_B  | dividing for the offset (or column position)
//   COMMIT | publish m, b / xc and vert_mode together
module lr_line_fit
  import lr_pkg::*;
(
  input logic          clk_65mhz,
  input logic          rst_in,
  lr_line_fit_if.slave vid
);
  localparam int YL_W  = ACC_W + H_W + 2;
  localparam int ROUND = 1 << (FRAC_BITS - 1);
  typedef logic signed [YL_W-1:0] yl_t;
  typedef logic signed [H_W+1:0]  dh_t;

  acc_t n_q, sx_q, sy_q, sxx_q, sxy_q;
  acc_t n_d, sx_d, sy_d, sxx_d, sxy_d;
  acc_t s_n_q, s_sx_q, s_sy_q, s_sxx_q, s_sxy_q;
  logic prev_zero_q, armed_q, cur_zero, frame_end, load_snap;
  logic [2*H_W-1:0]   xx_c;
  logic [H_W+V_W-1:0] xy_c;

  solve_state_e state_q, state_d;
  prod_t den_c, num_c, bnum_c, div_a, div_b, div_q;
  logic  div_start, div_busy, div_done;
  coef_t m_new_q, res_q, m_q, b_q;
  logic  vert_new_q, vert_mode_q, fit_valid_q;
  logic [H_W-1:0] xc_q;

  yl_t  yl_c, dv_c;
  dh_t  dh_c;
  logic hit_line, hit_vert, line_q;

  // Frame end: raster wraps to (0,0); staying at (0,0) is not a new frame.
  assign cur_zero  = (vid.hcount == '0) && (vid.vcount == '0);
  assign frame_end = cur_zero && !prev_zero_q;
  // armed_q keeps a frame that began before reset release from being solved.
  assign load_snap = (state_q == IDLE) && frame_end && armed_q && (n_q != '0);

  always_comb begin
    xx_c  = {{H_W{1'b0}}, vid.hcount} * {{H_W{1'b0}}, vid.hcount};
    xy_c  = {{V_W{1'b0}}, vid.hcount} * {{H_W{1'b0}}, vid.vcount};
    n_d   = frame_end ? '0 : n_q;
    sx_d  = frame_end ? '0 : sx_q;
    sy_d  = frame_end ? '0 : sy_q;
    sxx_d = frame_end ? '0 : sxx_q;
    sxy_d = frame_end ? '0 : sxy_q;
    if (vid.mask_cr) begin
      n_d   = sat_add(n_d, acc_t'(1));
      sx_d  = sat_add(sx_d, acc_t'(vid.hcount));
      sy_d  = sat_add(sy_d, acc_t'(vid.vcount));
      sxx_d = sat_add(sxx_d, acc_t'(xx_c));
      sxy_d = sat_add(sxy_d, acc_t'(xy_c));
    end
  end

  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      n_q <= '0; sx_q <= '0; sy_q <= '0; sxx_q <= '0; sxy_q <= '0;
      prev_zero_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      n_q <= n_d; sx_q <= sx_d; sy_q <= sy_d; sxx_q <= sxx_d; sxy_q <= sxy_d;
      prev_zero_q <= cur_zero;
      if (frame_end) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    div_a     = '0;
    div_b     = '0;
    den_c  = prod_t'(s_n_q) * prod_t'(s_sxx_q) - prod_t'(s_sx_q) * prod_t'(s_sx_q);
    num_c  = prod_t'(s_n_q) * prod_t'(s_sxy_q) - prod_t'(s_sx_q) * prod_t'(s_sy_q);
    bnum_c = (prod_t'(s_sy_q) <<< FRAC_BITS) - prod_t'(m_new_q) * prod_t'(s_sx_q);
    case (state_q)
      IDLE:   if (load_snap) state_d = MUL;
      MUL: begin
        div_start = !div_busy;
        if (den_c == '0) begin
          // single column: only xc = Sx/n is meaningful
          div_a = prod_t'(s_sx_q);
          div_b = prod_t'(s_n_q);
          if (!div_busy) state_d = DIV_B;
        end else begin
          div_a = num_c <<< FRAC_BITS;
          div_b = den_c;
          if (!div_busy) state_d = DIV_M;
        end
      end
      DIV_M:  if (div_done) state_d = MUL_B;
      MUL_B: begin
        div_start = !div_busy;
        div_a     = bnum_c;
        div_b     = prod_t'(s_n_q);
        if (!div_busy) state_d = DIV_B;
      end
      DIV_B:  if (div_done) state_d = COMMIT;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      s_n_q <= '0; s_sx_q <= '0; s_sy_q <= '0; s_sxx_q <= '0; s_sxy_q <= '0;
      m_new_q <= '0; res_q <= '0; vert_new_q <= 1'b0;
      m_q <= '0; b_q <= '0; xc_q <= '0;
      vert_mode_q <= 1'b0;
      fit_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_snap) begin
        s_n_q <= n_q; s_sx_q <= sx_q; s_sy_q <= sy_q; s_sxx_q <= sxx_q; s_sxy_q <= sxy_q;
      end
      if (state_q == MUL) vert_new_q <= (den_c == '0);
      if (state_q == DIV_M && div_done) m_new_q <= coef_t'(div_q);
      if (state_q == DIV_B && div_done) res_q <= coef_t'(div_q);
      if (state_q == COMMIT) begin
        vert_mode_q <= vert_new_q;
        fit_valid_q <= 1'b1;
        if (vert_new_q) begin
          xc_q <= res_q[H_W-1:0];
        end else begin
          m_q <= m_new_q;
          b_q <= res_q;
        end
      end
    end
  end

  lr_divider #(.W(PROD_W)) u_div (
    .clk_65mhz (clk_65mhz),
    .rst_in    (rst_in),
    .start_i   (div_start),
    .dividend_i(div_a),
    .divisor_i (div_b),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_q)
  );

  always_comb begin
    yl_c = (yl_t'(m_q) * yl_t'({1'b0, vid.hcount}) + yl_t'(b_q) + yl_t'(ROUND)) >>> FRAC_BITS;
    dv_c = yl_t'({1'b0, vid.vcount}) - yl_c;
    dh_c = $signed({2'b00, vid.hcount}) - $signed({2'b00, xc_q});
`ifdef LR_THICK_EN
    hit_line = (dv_c >= yl_t'(-TOL)) && (dv_c <= yl_t'(TOL));
    hit_vert = (dh_c >= dh_t'(-TOL)) && (dh_c <= dh_t'(TOL));
`else
    // vcount is never negative, so equality already rejects out-of-range yl
    hit_line = (dv_c == '0);
    hit_vert = (dh_c == '0);
`endif
  end

  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) line_q <= 1'b0;
    else         line_q <= fit_valid_q && (vert_mode_q ? hit_vert : hit_line);
  end

  assign vid.lin_reg_line = line_q;
endmodule

// File: tb/tb_lr_line_fit.sv
// Directed bench for lr_line_fit. Vertical blank is modelled as the raster
// parked at (0,0) with mask off, giving the solver time before the next
// active scan; outputs of each scanned frame are captured into line_map.
module tb_lr_line_fit;
  logic clk_65mhz = 1'b0;
  logic rst_in    = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic line_map [0:63][0:99];

  lr_line_fit_if vid();

  lr_line_fit dut (
    .clk_65mhz(clk_65mhz),
    .rst_in   (rst_in),
    .vid      (vid)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic mask_fn(int mode, int h, int v);
    case (mode)
      1:       return (h <= 9) && (v == 2 * h + 1);
      2:       return (h <= 7) && (v == 7 - h);
      3:       return (h >= 1) && (h <= 2) && (v == 4 * h - 1);
      4:       return (h == 50) && (v <= 99);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int count_all(int hmax, int vmax);
    int c = 0;
    for (int h = 0; h < hmax; h++)
      for (int v = 0; v < vmax; v++)
        if (line_map[h][v]) c++;
    return c;
  endfunction

  function automatic int count_col(int h, int vmax);
    int c = 0;
    for (int v = 0; v < vmax; v++)
      if (line_map[h][v]) c++;
    return c;
  endfunction

  // One frame: blank at (0,0), then scan hmax x vmax. Optionally pulse reset
  // right after the pixel (rst_h, rst_v) has been sampled.
  task automatic run_frame(input int mode, input int hmax, input int vmax,
                           input int rst_h, input int rst_v);
    vid.hcount  = '0;
    vid.vcount  = '0;
    vid.mask_cr = 1'b0;
    repeat (220) @(posedge clk_65mhz);
    #1;
    for (int h = 0; h < 64; h++)
      for (int v = 0; v < 100; v++)
        line_map[h][v] = 1'b0;
    for (int v = 0; v < vmax; v++) begin
      for (int h = 0; h < hmax; h++) begin
        vid.hcount  = 11'(h);
        vid.vcount  = 10'(v);
        vid.mask_cr = mask_fn(mode, h, v);
        @(posedge clk_65mhz);
        #1;
        line_map[h][v] = vid.lin_reg_line;
        if (h == rst_h && v == rst_v) begin
          chk("pre_reset_line", 32'(vid.lin_reg_line), 32'd1);
          rst_in = 1'b0;
          #1;
          chk("reset_line_now", 32'(vid.lin_reg_line), 32'd0);
          repeat (3) @(posedge clk_65mhz);
          #1;
          rst_in = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vid.hcount  = '0;
    vid.vcount  = '0;
    vid.mask_cr = 1'b0;
    repeat (3) @(posedge clk_65mhz);
    #1;
    chk("reset_line", 32'(vid.lin_reg_line), 32'd0);
    rst_in = 1'b1;

    // y = 2x+1 collected; nothing fitted yet
    run_frame(1, 16, 24, -1, -1);
    chk("no_fit_yet", 32'(count_all(16, 24)), 32'd0);

    // fit y=2x+1 drawn
    run_frame(2, 16, 24, -1, -1);
    chk("l1_3_7", 32'(line_map[3][7]), 32'd1);
    chk("l1_0_1", 32'(line_map[0][1]), 32'd1);
`ifdef LR_THICK_EN
    chk("l1_3_6_thick", 32'(line_map[3][6]), 32'd1);
    chk("l1_3_8_thick", 32'(line_map[3][8]), 32'd1);
    chk("l1_3_9_thick", 32'(line_map[3][9]), 32'd0);
`else
    chk("l1_3_6", 32'(line_map[3][6]), 32'd0);
    chk("l1_3_8", 32'(line_map[3][8]), 32'd0);
    chk("l1_count", 32'(count_all(16, 24)), 32'd12);
`endif

    // first frame shows y=7-x, later frames y=4x-1 held stable
    for (int k = 0; k < 5; k++) begin
      run_frame(3, 16, 24, -1, -1);
      if (k == 0) begin
        chk("l2_2_5", 32'(line_map[2][5]), 32'd1);
        chk("l2_col9", 32'(count_col(9, 24)), 32'd0);
`ifndef LR_THICK_EN
        chk("l2_2_6", 32'(line_map[2][6]), 32'd0);
        chk("l2_count", 32'(count_all(16, 24)), 32'd8);
`endif
      end else begin
        chk($sformatf("l3_2_7_f%0d", k), 32'(line_map[2][7]), 32'd1);
        chk($sformatf("l3_0_0_f%0d", k), 32'(line_map[0][0]), 32'd0);
`ifndef LR_THICK_EN
        chk($sformatf("l3_count_f%0d", k), 32'(count_all(16, 24)), 32'd6);
`endif
      end
    end

    // column mask at h=50; this frame still shows y=4x-1
    run_frame(4, 64, 100, -1, -1);
    chk("l3_last_2_7", 32'(line_map[2][7]), 32'd1);
`ifndef LR_THICK_EN
    chk("l3_big_count", 32'(count_all(64, 100)), 32'd25);
`endif

    // vertical fit drawn; this frame is empty
    run_frame(0, 64, 100, -1, -1);
    chk("vert_col50", 32'(count_col(50, 100)), 32'd100);
`ifndef LR_THICK_EN
    chk("vert_count", 32'(count_all(64, 100)), 32'd100);
`endif

    // after an empty frame the previous fit stays
    run_frame(0, 64, 100, -1, -1);
    chk("empty_keeps_col50", 32'(count_col(50, 100)), 32'd100);
    chk("empty_keeps_col49", 32'(line_map[49][20]), 32'(`ifdef LR_THICK_EN 1 `else 0 `endif));

    // reset mid-frame while the vertical line is being drawn
    run_frame(1, 64, 100, 50, 10);

    // partial frame after reset must not be fitted
    run_frame(1, 16, 24, -1, -1);
    chk("no_fit_after_reset", 32'(count_all(16, 24)), 32'd0);

    // first full frame after reset is fitted again
    run_frame(0, 16, 24, -1, -1);
    chk("refit_3_7", 32'(line_map[3][7]), 32'd1);
    chk("refit_0_1", 32'(line_map[0][1]), 32'd1);
`ifndef LR_THICK_EN
    chk("refit_count", 32'(count_all(16, 24)), 32'd12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
